pacman_move_ctrl: RTL and testbench

- Upstream stage of the map RAM writer. Turns player direction buttons into a one-tile Pac-Man move request once per move period.
- Checks the candidate tile against the map RAM for a wall, then presents a stable curr/next pair with ready.
- Holds that pair until the writer's pac_done, then commits next into curr.

---
 rtl/pacman_move_ctrl.sv | 149 ++++++++++++++
 tb/tb_pacman_move_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_move_ctrl.sv
// Pac-Man move request generator: samples direction buttons, checks the candidate
// tile in map RAM for a wall, and holds a curr/next request until the writer commits it.
module pacman_move_ctrl #(
    parameter int         MAP_W       = 40,
    parameter int         MAP_H       = 30,
    parameter int         START_X     = 20,
    parameter int         START_Y     = 22,
    parameter logic [3:0] WALL_CODE   = 4'd3,
    parameter int         MOVE_PERIOD = 2500000
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         up,
    input  logic         down,
    input  logic         left,
    input  logic         right,
    input  logic         done,
    input  logic [159:0] rddata,
    output logic [4:0]   rdaddr,
    output logic [5:0]   curr_pacman_x,
    output logic [4:0]   curr_pacman_y,
    output logic [5:0]   next_pacman_x,
    output logic [4:0]   next_pacman_y,
    output logic         ready,
    output logic         blocked
);

    localparam int              CNT_W   = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOVE_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, PENDING} state_t;
    typedef enum logic [2:0] {HEAD_NONE, HEAD_UP, HEAD_DOWN, HEAD_LEFT, HEAD_RIGHT} head_t;

    state_t           state_q, state_d;
    head_t            head_q, head_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       curr_x_q, curr_x_d, next_x_q, next_x_d, cand_x_q, cand_x_d;
    logic [4:0]       curr_y_q, curr_y_d, next_y_q, next_y_d, cand_y_q, cand_y_d;
    logic             ready_q, ready_d, blocked_q, blocked_d;
    logic             tick;
    logic [7:0]       tile_lsb;
    logic [3:0]       tile;

    function automatic logic [5:0] step_x(input logic [5:0] x, input head_t h);
        if (h == HEAD_LEFT)  return (x == 6'd0) ? 6'(MAP_W - 1) : x - 6'd1;
        if (h == HEAD_RIGHT) return (x == 6'(MAP_W - 1)) ? 6'd0 : x + 6'd1;
        return x;
    endfunction

    function automatic logic [4:0] step_y(input logic [4:0] y, input head_t h);
        if (h == HEAD_UP)   return (y == 5'd0) ? 5'(MAP_H - 1) : y - 5'd1;
        if (h == HEAD_DOWN) return (y == 5'(MAP_H - 1)) ? 5'd0 : y + 5'd1;
        return y;
    endfunction

    assign tick     = (cnt_q == CNT_MAX);
    // Column 0 sits in the most significant nibble of the row.
    assign tile_lsb = 8'd156 - {cand_x_q, 2'b00};
    assign tile     = rddata[tile_lsb +: 4];
    assign rdaddr   = (state_q == IDLE) ? curr_y_q : cand_y_q;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        curr_x_d  = curr_x_q;
        curr_y_d  = curr_y_q;
        next_x_d  = next_x_q;
        next_y_d  = next_y_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        ready_d   = ready_q;
        blocked_d = 1'b0;

        if (up)         head_d = HEAD_UP;
        else if (down)  head_d = HEAD_DOWN;
        else if (left)  head_d = HEAD_LEFT;
        else if (right) head_d = HEAD_RIGHT;

        case (state_q)
            IDLE: begin
                if (tick && head_q != HEAD_NONE) begin
                    cand_x_d = step_x(curr_x_q, head_q);
                    cand_y_d = step_y(curr_y_q, head_q);
                    state_d  = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = CHECK;
            CHECK: begin
                if (tile == WALL_CODE) begin
                    blocked_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    next_x_d = cand_x_q;
                    next_y_d = cand_y_q;
                    ready_d  = 1'b1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                // Ticks landing here are simply lost; only done moves us on.
                if (done) begin
                    curr_x_d = next_x_q;
                    curr_y_d = next_y_q;
                    ready_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            head_q    <= HEAD_NONE;
            cnt_q     <= '0;
            curr_x_q  <= 6'(START_X);
            curr_y_q  <= 5'(START_Y);
            next_x_q  <= 6'(START_X);
            next_y_q  <= 5'(START_Y);
            cand_x_q  <= 6'(START_X);
            cand_y_q  <= 5'(START_Y);
            ready_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            cnt_q     <= cnt_d;
            curr_x_q  <= curr_x_d;
            curr_y_q  <= curr_y_d;
            next_x_q  <= next_x_d;
            next_y_q  <= next_y_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            ready_q   <= ready_d;
            blocked_q <= blocked_d;
        end
    end

    assign curr_pacman_x = curr_x_q;
    assign curr_pacman_y = curr_y_q;
    assign next_pacman_x = next_x_q;
    assign next_pacman_y = next_y_q;
    assign ready         = ready_q;
    assign blocked       = blocked_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Scoreboard bench for pacman_move_ctrl: stimulus queues expected requests/blocks,
// a negedge monitor pops and compares them when ready rises or blocked pulses.
module tb_pacman_move_ctrl;

    localparam logic [3:0] B_U  = 4'b1000;
    localparam logic [3:0] B_UL = 4'b1010;
    localparam logic [3:0] B_L  = 4'b0010;
    localparam logic [3:0] B_R  = 4'b0001;
    localparam logic [3:0] B_0  = 4'b0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, done = 1'b0;
    logic [159:0] rddata;
    logic [4:0]   rdaddr;
    logic [5:0]   cx, nx;
    logic [4:0]   cy, ny;
    logic         ready, blocked;

    logic [159:0] mem [0:31];
    logic [4:0]   addr_p1;

    typedef struct {
        bit is_blk;
        int nx, ny, cx, cy;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_bad = 0, n_blk = 0;
    int   px = 20, py = 22, hd = 0;
    logic ready_prev = 1'b0;

    pacman_move_ctrl #(.MOVE_PERIOD(4)) dut (
        .CLOCK_50(clk), .reset(rst_n),
        .up(up), .down(down), .left(left), .right(right),
        .done(done), .rddata(rddata), .rdaddr(rdaddr),
        .curr_pacman_x(cx), .curr_pacman_y(cy),
        .next_pacman_x(nx), .next_pacman_y(ny),
        .ready(ready), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // Map RAM: data appears two edges after the address is presented.
    always @(posedge clk) begin
        addr_p1 <= rdaddr;
        rddata  <= mem[addr_p1];
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, "_curr_x"}, int'(cx), x);
        chk({tag, "_curr_y"}, int'(cy), y);
        chk({tag, "_next_x"}, int'(nx), x);
        chk({tag, "_next_y"}, int'(ny), y);
    endtask

    function automatic int pri(input logic [3:0] b);
        if (b[3]) return 1;
        if (b[2]) return 2;
        if (b[1]) return 3;
        if (b[0]) return 4;
        return 0;
    endfunction

    task automatic set_btn(input logic [3:0] b);
        {up, down, left, right} = b;
        if (b != 4'b0000) hd = pri(b);
    endtask

    task automatic model_step();
        case (hd)
            1: py = (py == 0) ? 29 : py - 1;
            2: py = (py == 29) ? 0 : py + 1;
            3: px = (px == 0) ? 39 : px - 1;
            4: px = (px == 39) ? 0 : px + 1;
            default: ;
        endcase
    endtask

    task automatic set_tile(input int x, input int y, input logic [3:0] c);
        mem[y][156-4*x +: 4] = c;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1 && ready_prev !== 1'b1) begin
            if (q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_ready: got next=(%0d,%0d), required no request", nx, ny);
            end else begin
                e = q.pop_front();
                chk("req_kind_is_blocked", int'(e.is_blk), 0);
                chk("req_next_x", int'(nx), e.nx);
                chk("req_next_y", int'(ny), e.ny);
                chk("req_curr_x", int'(cx), e.cx);
                chk("req_curr_y", int'(cy), e.cy);
            end
        end
        if (blocked === 1'b1) begin
            n_blk++;
            if (q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_blocked: got blocked=1 at curr=(%0d,%0d), required 0", cx, cy);
            end else begin
                e = q.pop_front();
                chk("blk_kind_is_blocked", int'(e.is_blk), 1);
                chk("blk_ready", int'(ready), 0);
                chk("blk_curr_x", int'(cx), e.cx);
                chk("blk_curr_y", int'(cy), e.cy);
                chk("blk_next_x", int'(nx), e.nx);
                chk("blk_next_y", int'(ny), e.ny);
            end
        end
        ready_prev = ready;
    end

    task automatic push_exp(input bit blk, input int ex, input int ey, input int ox, input int oy);
        exp_t e;
        e.is_blk = blk; e.nx = ex; e.ny = ey; e.cx = ox; e.cy = oy;
        q.push_back(e);
    endtask

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        ok = (ready === 1'b1);
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", ready, t);
        end
    endtask

    // One full move: buttons now_b, expect request, hold, switch to next_b, commit.
    task automatic move(input logic [3:0] now_b, input logic [3:0] next_b, input int hold);
        int ox = px, oy = py;
        bit ok, stable;
        set_btn(now_b);
        model_step();
        push_exp(1'b0, px, py, ox, oy);
        wait_ready(ok);
        if (!ok) return;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (nx !== 6'(px) || ny !== 5'(py) || ready !== 1'b1 || rdaddr !== 5'(py)) stable = 1'b0;
        end
        chk("pending_stable", int'(stable), 1);
        set_btn(next_b);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_pos("commit", px, py);
        chk("commit_ready", int'(ready), 0);
        chk("commit_rdaddr", int'(rdaddr), py);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit ok;
        for (int y = 0; y < 32; y++) mem[y] = '0;
        set_tile(20, 21, 4'h3);
        set_tile(5, 22, 4'h3);
        set_tile(0, 5, 4'h7);

        repeat (3) @(negedge clk);
        chk_pos("in_reset", 20, 22);
        chk("in_reset_ready", int'(ready), 0);
        chk("in_reset_rdaddr", int'(rdaddr), 22);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_pos("idle_no_btn", 20, 22);
        chk("idle_no_btn_ready", int'(ready), 0);
        chk("idle_no_btn_blocked", int'(blocked), 0);
        chk("idle_no_btn_rdaddr", int'(rdaddr), 22);

        move(B_R, B_L, 3);
        move(B_L, B_U, 3);

        push_exp(1'b1, 20, 22, 20, 22);
        t = 0;
        while (rdaddr !== 5'd21 && t < 20) begin @(negedge clk); t++; end
        chk("fetch_rdaddr", int'(rdaddr), 21);
        set_btn(B_R);
        t = n_blk;
        for (int i = 0; i < 20 && n_blk == t; i++) @(negedge clk);
        chk("blocked_seen", n_blk - t, 1);
        chk_pos("after_block", 20, 22);
        chk("after_block_ready", int'(ready), 0);

        move(B_R, B_R, 3);
        for (int i = 0; i < 18; i++) move(B_R, (i == 17) ? B_UL : B_R, 3);
        chk("row_end_x", int'(cx), 39);
        move(B_UL, B_0, 3);
        chk("up_priority_y", int'(cy), 21);
        for (int i = 0; i < 15; i++) move(B_0, B_0, (i == 4) ? 10 : 3);
        move(B_0, B_R, 3);
        chk_pos("at_39_5", 39, 5);
        move(B_R, B_R, 3);
        chk_pos("wrap_right", 0, 5);
        move(B_R, B_R, 3);
        move(B_R, B_R, 3);
        move(B_R, B_U, 3);
        for (int i = 0; i < 5; i++) move(B_U, B_U, 3);
        chk_pos("at_3_0", 3, 0);
        move(B_U, B_0, 3);
        chk_pos("wrap_up", 3, 29);

        rst_n = 1'b0;
        set_btn(B_0);
        hd = 0; px = 20; py = 22;
        repeat (2) @(negedge clk);
        chk_pos("rereset", 20, 22);
        chk("rereset_ready", int'(ready), 0);
        rst_n = 1'b1;

        set_btn(B_R);
        push_exp(1'b0, 21, 22, 20, 22);
        wait_ready(ok);
        set_btn(B_0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", int'(ready), 0);
        chk_pos("async_rst", 20, 22);
        chk("async_rst_rdaddr", int'(rdaddr), 22);
        @(negedge clk);
        rst_n = 1'b1;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_pos("late_done", 20, 22);
        chk("late_done_ready", int'(ready), 0);
        repeat (16) @(negedge clk);
        chk_pos("final_idle", 20, 22);
        chk("final_ready", int'(ready), 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
